// File: rtl/sh_ext_mem_ctrl_if.sv
// sh_ext_mem_ctrl_if -- external memory request bus between the controller and a memory model.
//   MEM_A   [26:0] latched access address          (controller -> memory)
//   MEM_D   [31:0] latched write data              (controller -> memory)
//   MEM_BE  [3:0]  active-high byte enables        (controller -> memory)
//   MEM_WE         1 = write, 0 = read             (controller -> memory)
//   MEM_CS  [1:0]  serviced area index             (controller -> memory)
//   MEM_REQ        one-CE_R-tick request strobe    (controller -> memory)
//   MEM_Q   [31:0] read data                       (memory -> controller)
//   MEM_ACK        one-cycle completion strobe     (memory -> controller)
// Modport master is the controller side, slave is the memory side.
interface sh_ext_mem_ctrl_if;
    logic [26:0] MEM_A;
    logic [31:0] MEM_D;
    logic [3:0]  MEM_BE;
    logic        MEM_WE;
    logic [1:0]  MEM_CS;
    logic        MEM_REQ;
    logic [31:0] MEM_Q;
    logic        MEM_ACK;

    modport master (
        output MEM_A, MEM_D, MEM_BE, MEM_WE, MEM_CS, MEM_REQ,
        input  MEM_Q, MEM_ACK
    );

    modport slave (
        input  MEM_A, MEM_D, MEM_BE, MEM_WE, MEM_CS, MEM_REQ,
        output MEM_Q, MEM_ACK
    );
endinterface

// File: rtl/sh_ext_mem_ctrl.sv
// sh_ext_mem_ctrl -- bridges SH-style CPU bus cycles on areas CS0..CS3 to a request/ack memory.
//   CLK, RST_N       clock, asynchronous active-low reset
//   CE_R, CE_F       rising / falling phase clock enables (all state moves on CE_R)
//   A, DO, DI        CPU address, CPU write data, read data returned to CPU
//   BS_N, CSn_N      bus start and area selects; RD_WR_N 1 = read; RD_N read strobe
//   WE_N[3:0]        byte write strobes, WE_N[3] = D31-24
//   WAIT_N           wait request to CPU, combinational so it is seen in T1
//   TOUT             one-CE_R-tick pulse when an access is force-completed
//   mem              memory request bus (master side)
module sh_ext_mem_ctrl #(
    parameter logic [3:0]  CS_MASK = 4'b1111,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     CE_R,
    input  logic                     CE_F,
    input  logic [26:0]              A,
    input  logic [31:0]              DO,
    output logic [31:0]              DI,
    input  logic                     BS_N,
    input  logic                     CS0_N,
    input  logic                     CS1_N,
    input  logic                     CS2_N,
    input  logic                     CS3_N,
    input  logic                     RD_WR_N,
    input  logic                     RD_N,
    input  logic [3:0]               WE_N,
    output logic                     WAIT_N,
    output logic                     TOUT,
    sh_ext_mem_ctrl_if.master        mem
);

    // At least 8 bits, wider only when TIMEOUT needs it.
    localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT) + 1 : 8;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] WAIT_ACK = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            timed_out;
    logic [3:0]      cs_act;
    logic            start;
    logic [1:0]      area;

    logic [26:0] mem_a_q;
    logic [31:0] mem_d_q;
    logic [3:0]  mem_be_q;
    logic        mem_we_q;
    logic [1:0]  mem_cs_q;
    logic [31:0] di_q;
    logic        tout_q;

    // Only areas enabled in CS_MASK can start an access.
    assign cs_act = ~{CS3_N, CS2_N, CS1_N, CS0_N} & CS_MASK;
    assign start  = ~BS_N & (|cs_act);

    // Lowest-numbered active area wins.
    always_comb begin
        area = 2'd0;
        if (cs_act[0]) begin
            area = 2'd0;
        end else if (cs_act[1]) begin
            area = 2'd1;
        end else if (cs_act[2]) begin
            area = 2'd2;
        end else if (cs_act[3]) begin
            area = 2'd3;
        end
    end

    // Saturating increment; timeout fires on the TIMEOUT-th unanswered WAIT_ACK tick.
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign timed_out = 64'(cnt_inc) >= 64'(TIMEOUT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = REQ;
            end
            REQ: begin
                // MEM_ACK is deliberately not looked at here.
                state_d = WAIT_ACK;
                cnt_d   = '0;
            end
            WAIT_ACK: begin
                if (mem.MEM_ACK) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (timed_out) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mem_a_q  <= '0;
            mem_d_q  <= '0;
            mem_be_q <= '0;
            mem_we_q <= 1'b0;
            mem_cs_q <= '0;
            di_q     <= '0;
            tout_q   <= 1'b0;
        end else if (CE_R) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tout_q  <= (state_q == WAIT_ACK) && !mem.MEM_ACK && timed_out;
            if (state_q == IDLE && start) begin
                mem_a_q  <= A;
                mem_d_q  <= DO;
                mem_we_q <= ~RD_WR_N;
                mem_be_q <= RD_WR_N ? 4'b1111 : ~WE_N;
                mem_cs_q <= area;
            end
            // Writes never touch DI, so the last read value stays visible.
            if (state_q == WAIT_ACK && !mem_we_q) begin
                if (mem.MEM_ACK) begin
                    di_q <= mem.MEM_Q;
                end else if (timed_out) begin
                    di_q <= 32'hFFFF_FFFF;
                end
            end
        end
    end

    // Reset overrides a pending start so WAIT_N is released while RST_N is low.
    assign WAIT_N = ~(RST_N & ((state_q == REQ) || (state_q == WAIT_ACK) ||
                               ((state_q == IDLE) && start)));

    assign mem.MEM_REQ = (state_q == REQ);
    assign mem.MEM_A   = mem_a_q;
    assign mem.MEM_D   = mem_d_q;
    assign mem.MEM_BE  = mem_be_q;
    assign mem.MEM_WE  = mem_we_q;
    assign mem.MEM_CS  = mem_cs_q;
    assign DI          = di_q;
    assign TOUT        = tout_q;

    // Falling-phase enable and read strobe carry no extra information for this protocol.
    logic unused_inputs;
    assign unused_inputs = ^{CE_F, RD_N};

endmodule

// File: tb/tb_sh_ext_mem_ctrl.sv
module tb_sh_ext_mem_ctrl;

    localparam logic [3:0]  MASK = 4'b0111;
    localparam int unsigned TMO  = 4;

    logic        CLK = 1'b0;
    logic        RST_N, CE_R, CE_F;
    logic [26:0] A;
    logic [31:0] DO, DI;
    logic        BS_N, CS0_N, CS1_N, CS2_N, CS3_N, RD_WR_N, RD_N;
    logic [3:0]  WE_N;
    logic        WAIT_N, TOUT;

    sh_ext_mem_ctrl_if mem_if ();

    sh_ext_mem_ctrl #(
        .CS_MASK (MASK),
        .TIMEOUT (TMO)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .CE_R    (CE_R),
        .CE_F    (CE_F),
        .A       (A),
        .DO      (DO),
        .DI      (DI),
        .BS_N    (BS_N),
        .CS0_N   (CS0_N),
        .CS1_N   (CS1_N),
        .CS2_N   (CS2_N),
        .CS3_N   (CS3_N),
        .RD_WR_N (RD_WR_N),
        .RD_N    (RD_N),
        .WE_N    (WE_N),
        .WAIT_N  (WAIT_N),
        .TOUT    (TOUT),
        .mem     (mem_if.master)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] di_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CE_R tick; returns 1 time unit after a clock edge with CE_R low.
    task automatic step();
        CE_R = 1'b1;
        @(posedge CLK);
        #1;
        CE_R = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle_bus();
        BS_N = 1'b1;
        {CS3_N, CS2_N, CS1_N, CS0_N} = 4'hF;
    endtask

    function automatic int exp_area(input logic [3:0] cs_n);
        for (int i = 0; i < 4; i++) begin
            if (!cs_n[i] && MASK[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_reset_values();
        check("rst_wait_n", {31'd0, WAIT_N}, 32'd1);
        check("rst_mem_req", {31'd0, mem_if.MEM_REQ}, 32'd0);
        check("rst_mem_we", {31'd0, mem_if.MEM_WE}, 32'd0);
        check("rst_mem_be", {28'd0, mem_if.MEM_BE}, 32'd0);
        check("rst_mem_a", {5'd0, mem_if.MEM_A}, 32'd0);
        check("rst_mem_cs", {30'd0, mem_if.MEM_CS}, 32'd0);
        check("rst_mem_d", mem_if.MEM_D, 32'd0);
        check("rst_di", DI, 32'd0);
        check("rst_tout", {31'd0, TOUT}, 32'd0);
    endtask

    // One CPU access. ack_at = WAIT_ACK tick carrying MEM_ACK (beyond TMO means none),
    // b2b = CPU starts its next cycle during DONE, rst_at = WAIT_ACK tick to pulse reset (0 = never).
    task automatic access(input logic [3:0] cs_n, input logic rd, input logic [26:0] addr,
                          input logic [31:0] wdata, input logic [3:0] we_n, input int ack_at,
                          input logic [31:0] q, input bit b2b, input int rst_at);
        int  area;
        bit  tmo;
        bit  ack;
        area = exp_area(cs_n);
        tmo  = (ack_at < 1) || (ack_at > int'(TMO));
        {CS3_N, CS2_N, CS1_N, CS0_N} = cs_n;
        BS_N    = 1'b0;
        A       = addr;
        DO      = wdata;
        RD_WR_N = rd;
        RD_N    = ~rd;
        WE_N    = rd ? 4'hF : we_n;
        mem_if.MEM_ACK = 1'b0;
        #1;
        if (area < 0) begin
            check("ign_wait_n", {31'd0, WAIT_N}, 32'd1);
            check("ign_mem_req", {31'd0, mem_if.MEM_REQ}, 32'd0);
            step();
            check("ign_wait_n_after", {31'd0, WAIT_N}, 32'd1);
            check("ign_mem_req_after", {31'd0, mem_if.MEM_REQ}, 32'd0);
            idle_bus();
            return;
        end
        check("idle_wait_n", {31'd0, WAIT_N}, 32'd0);
        check("idle_mem_req", {31'd0, mem_if.MEM_REQ}, 32'd0);
        step();
        // CPU lines scrambled and selects dropped: latched values must hold, access must go on.
        idle_bus();
        A       = 27'($urandom);
        DO      = $urandom;
        WE_N    = 4'($urandom);
        RD_WR_N = 1'($urandom);
        mem_if.MEM_ACK = 1'($urandom);
        mem_if.MEM_Q   = $urandom;
        #1;
        check("req_mem_req", {31'd0, mem_if.MEM_REQ}, 32'd1);
        check("req_wait_n", {31'd0, WAIT_N}, 32'd0);
        check("req_mem_a", {5'd0, mem_if.MEM_A}, {5'd0, addr});
        check("req_mem_cs", {30'd0, mem_if.MEM_CS}, 32'(area));
        check("req_mem_we", {31'd0, mem_if.MEM_WE}, {31'd0, ~rd});
        check("req_mem_be", {28'd0, mem_if.MEM_BE}, rd ? 32'hF : {28'd0, ~we_n});
        check("req_mem_d", mem_if.MEM_D, wdata);
        step();
        for (int n = 1; n <= int'(TMO); n++) begin
            ack = (n == ack_at);
            mem_if.MEM_ACK = ack;
            mem_if.MEM_Q   = ack ? q : $urandom;
            #1;
            if (n == rst_at) begin
                RST_N = 1'b0;
                BS_N  = 1'b0;
                CS0_N = 1'b0;
                #1;
                di_model = 32'd0;
                check_reset_values();
                @(posedge CLK);
                #1;
                idle_bus();
                RST_N = 1'b1;
                mem_if.MEM_ACK = 1'b1;
                mem_if.MEM_Q   = $urandom;
                step();
                mem_if.MEM_ACK = 1'b0;
                #1;
                check("late_ack_wait_n", {31'd0, WAIT_N}, 32'd1);
                check("late_ack_mem_req", {31'd0, mem_if.MEM_REQ}, 32'd0);
                check("late_ack_di", DI, di_model);
                check("late_ack_tout", {31'd0, TOUT}, 32'd0);
                return;
            end
            check("wait_wait_n", {31'd0, WAIT_N}, 32'd0);
            check("wait_mem_req", {31'd0, mem_if.MEM_REQ}, 32'd0);
            check("wait_tout", {31'd0, TOUT}, 32'd0);
            step();
            if (ack) break;
        end
        if (rd) di_model = tmo ? 32'hFFFF_FFFF : q;
        // Stray strobe outside WAIT_ACK must be ignored.
        mem_if.MEM_ACK = 1'($urandom);
        mem_if.MEM_Q   = $urandom;
        if (b2b) begin
            BS_N    = 1'b0;
            CS1_N   = 1'b0;
            RD_WR_N = 1'b1;
        end
        #1;
        check("done_wait_n", {31'd0, WAIT_N}, 32'd1);
        check("done_mem_req", {31'd0, mem_if.MEM_REQ}, 32'd0);
        check("done_tout", {31'd0, TOUT}, {31'd0, tmo});
        check("done_di", DI, di_model);
        step();
        mem_if.MEM_ACK = 1'b0;
        if (!b2b) idle_bus();
        #1;
        check("post_tout", {31'd0, TOUT}, 32'd0);
        check("post_di", DI, di_model);
        if (!b2b) check("post_wait_n", {31'd0, WAIT_N}, 32'd1);
    endtask

    initial begin
        RST_N   = 1'b0;
        CE_R    = 1'b0;
        CE_F    = 1'b0;
        A       = '0;
        DO      = '0;
        RD_WR_N = 1'b1;
        RD_N    = 1'b1;
        WE_N    = 4'hF;
        mem_if.MEM_Q   = '0;
        mem_if.MEM_ACK = 1'b0;
        di_model = 32'd0;
        idle_bus();
        repeat (3) @(posedge CLK);
        #1;
        check_reset_values();
        RST_N = 1'b1;

        // Read CS1, ack on the third tick after the request.
        access(4'b1101, 1'b1, 27'h0000100, 32'd0, 4'hF, 3, 32'h1234_5678, 1'b0, 0);
        // Byte write CS2, lane 1 only; DI must keep the previous read data.
        access(4'b1011, 1'b0, 27'($urandom), 32'h0000_AB00, 4'b1101, 2, $urandom, 1'b0, 0);
        // Read CS0 with no ack: forced completion.
        access(4'b1110, 1'b1, 27'($urandom), 32'd0, 4'hF, 99, 32'd0, 1'b0, 0);
        // CS3 is masked off.
        access(4'b0111, 1'b1, 27'($urandom), 32'd0, 4'hF, 1, $urandom, 1'b0, 0);
        // Priority: several selects low.
        access(4'b0000, 1'b1, 27'($urandom), 32'd0, 4'hF, 1, $urandom, 1'b0, 0);
        access(4'b1001, 1'b0, 27'($urandom), $urandom, 4'b0110, 4, $urandom, 1'b0, 0);
        // Back-to-back reads with the second bus start during DONE.
        access(4'b1101, 1'b1, 27'($urandom), 32'd0, 4'hF, 1, $urandom, 1'b1, 0);
        access(4'b1101, 1'b1, 27'($urandom), 32'd0, 4'hF, 2, $urandom, 1'b0, 0);
        // Reset pulsed during WAIT_ACK, then a fresh access straight away.
        access(4'b1110, 1'b1, 27'($urandom), 32'd0, 4'hF, 3, $urandom, 1'b0, 2);
        access(4'b1011, 1'b1, 27'($urandom), 32'd0, 4'hF, 1, $urandom, 1'b0, 0);

        for (int k = 0; k < 30; k++) begin
            access(4'($urandom), 1'($urandom), 27'($urandom), $urandom, 4'($urandom),
                   int'($urandom_range(1, TMO + 1)), $urandom, 1'($urandom),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, TMO)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
